// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient pipeline.
package sobel_pkg;

    typedef enum logic [1:0] {
        GM_GY   = 2'd0,
        GM_GX   = 2'd1,
        GM_MAG  = 2'd2,
        GM_RSVD = 2'd3
    } grad_mode_t;

    // Signed gradient needs two bits of 1-2-1 growth, one more for the difference sign.
    function automatic int grad_w(input int pixel_w);
        return pixel_w + 3;
    endfunction

    function automatic logic [31:0] sat_pix(input logic [31:0] mag, input int pixel_w);
        logic [31:0] max_val;
        max_val = (32'd1 << pixel_w) - 32'd1;
        return (mag > max_val) ? max_val : mag;
    endfunction

endpackage

// File: rtl/sobel_tap121.sv
// Combinational 1-2-1 weighted sum of three unsigned pixels.
module sobel_tap121 #(
    parameter int PIXEL_W = 8
) (
    input  logic [PIXEL_W-1:0] a,
    input  logic [PIXEL_W-1:0] b,
    input  logic [PIXEL_W-1:0] c,
    output logic [PIXEL_W+1:0] sum
);

    assign sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};

endmodule

// File: rtl/sobel_grad_pipe.sv
// Sobel gradient engine: 3x3 window in, gx/gy/magnitude, saturated pixel and edge flag out.
module sobel_grad_pipe
    import sobel_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int GRAD_W  = grad_w(PIXEL_W),
    parameter bit REG_OUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [9*PIXEL_W-1:0]   in_win,
    input  logic [1:0]             in_mode,
    input  logic [PIXEL_W-1:0]     in_thresh,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [GRAD_W-1:0]      out_grad,
    output logic [PIXEL_W-1:0]     out_pix,
    output logic                   out_edge,
    output logic                   out_last
);

    localparam int SUM_W = PIXEL_W + 2;

    logic [PIXEL_W-1:0] pix [9];
    logic [PIXEL_W-1:0] tap_a [4];
    logic [PIXEL_W-1:0] tap_b [4];
    logic [PIXEL_W-1:0] tap_c [4];
    logic [SUM_W-1:0]   tap_sum [4];

    for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
        assign pix[gi] = in_win[gi*PIXEL_W +: PIXEL_W];
    end

    // Tap order: 0 top row, 1 bottom row, 2 left column, 3 right column.
    always_comb begin
        tap_a[0] = pix[0]; tap_b[0] = pix[1]; tap_c[0] = pix[2];
        tap_a[1] = pix[6]; tap_b[1] = pix[7]; tap_c[1] = pix[8];
        tap_a[2] = pix[0]; tap_b[2] = pix[3]; tap_c[2] = pix[6];
        tap_a[3] = pix[2]; tap_b[3] = pix[5]; tap_c[3] = pix[8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
        sobel_tap121 #(.PIXEL_W(PIXEL_W)) u_tap (
            .a   (tap_a[gi]),
            .b   (tap_b[gi]),
            .c   (tap_c[gi]),
            .sum (tap_sum[gi])
        );
    end

    logic               s1_v_reg;
    logic [SUM_W-1:0]   s1_sum_reg [4];
    grad_mode_t         s1_mode_reg;
    logic [PIXEL_W-1:0] s1_thresh_reg;
    logic               s1_last_reg;
    logic               s2_free;
    logic               s1_adv;

    assign s1_adv   = s1_v_reg && s2_free;
    assign in_ready = !s1_v_reg || s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg      <= 1'b0;
            s1_mode_reg   <= GM_GY;
            s1_thresh_reg <= '0;
            s1_last_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) s1_sum_reg[i] <= '0;
        end else if (in_valid && in_ready) begin
            s1_v_reg      <= 1'b1;
            s1_mode_reg   <= grad_mode_t'(in_mode);
            s1_thresh_reg <= in_thresh;
            s1_last_reg   <= in_last;
            for (int i = 0; i < 4; i++) s1_sum_reg[i] <= tap_sum[i];
        end else if (s1_adv) begin
            s1_v_reg <= 1'b0;
        end
    end

    logic signed [GRAD_W-1:0] gx_c;
    logic signed [GRAD_W-1:0] gy_c;
    logic [GRAD_W-1:0]        gx_abs;
    logic [GRAD_W-1:0]        gy_abs;
    logic [GRAD_W-1:0]        mag_c;
    logic [GRAD_W-1:0]        grad_c;
    logic [GRAD_W-1:0]        grad_abs_c;
    logic [PIXEL_W-1:0]       pix_c;
    logic                     edge_c;

    always_comb begin
        gy_c   = $signed({1'b0, s1_sum_reg[1]}) - $signed({1'b0, s1_sum_reg[0]});
        gx_c   = $signed({1'b0, s1_sum_reg[3]}) - $signed({1'b0, s1_sum_reg[2]});
        gx_abs = gx_c[GRAD_W-1] ? GRAD_W'(-gx_c) : GRAD_W'(gx_c);
        gy_abs = gy_c[GRAD_W-1] ? GRAD_W'(-gy_c) : GRAD_W'(gy_c);
        // Worst case 8*(2^PIXEL_W-1) still fits GRAD_W unsigned, so no carry is lost.
        mag_c  = gx_abs + gy_abs;
        case (s1_mode_reg)
            GM_GY: begin
                grad_c     = GRAD_W'(gy_c);
                grad_abs_c = gy_abs;
            end
            GM_GX: begin
                grad_c     = GRAD_W'(gx_c);
                grad_abs_c = gx_abs;
            end
            default: begin
                grad_c     = mag_c;
                grad_abs_c = mag_c;
            end
        endcase
        pix_c  = PIXEL_W'(sat_pix(32'(grad_abs_c), PIXEL_W));
        edge_c = (pix_c >= s1_thresh_reg);
    end

    if (REG_OUT) begin : g_reg_out
        logic               s2_v_reg;
        logic [GRAD_W-1:0]  s2_grad_reg;
        logic [PIXEL_W-1:0] s2_pix_reg;
        logic               s2_edge_reg;
        logic               s2_last_reg;

        assign s2_free = !s2_v_reg || out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_v_reg    <= 1'b0;
                s2_grad_reg <= '0;
                s2_pix_reg  <= '0;
                s2_edge_reg <= 1'b0;
                s2_last_reg <= 1'b0;
            end else if (s1_adv) begin
                s2_v_reg    <= 1'b1;
                s2_grad_reg <= grad_c;
                s2_pix_reg  <= pix_c;
                s2_edge_reg <= edge_c;
                s2_last_reg <= s1_last_reg;
            end else if (out_ready) begin
                s2_v_reg <= 1'b0;
            end
        end

        assign out_valid = s2_v_reg;
        assign out_grad  = s2_grad_reg;
        assign out_pix   = s2_pix_reg;
        assign out_edge  = s2_edge_reg;
        assign out_last  = s2_last_reg;
    end else begin : g_comb_out
        // Reset leaves S1 threshold at 0, so flags are gated to keep them low while idle.
        assign s2_free   = out_ready;
        assign out_valid = s1_v_reg;
        assign out_grad  = grad_c;
        assign out_pix   = pix_c;
        assign out_edge  = s1_v_reg && edge_c;
        assign out_last  = s1_v_reg && s1_last_reg;
    end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Directed bench for sobel_grad_pipe (PIXEL_W=8, REG_OUT=1).
module tb_sobel_grad_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_win;
    logic [1:0]  in_mode;
    logic [7:0]  in_thresh;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_grad;
    logic [7:0]  out_pix;
    logic        out_edge;
    logic        out_last;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic [10:0] cap_grad;
    logic [7:0]  cap_pix;
    logic        cap_edge;
    logic        cap_last;

    sobel_grad_pipe #(.PIXEL_W(8), .REG_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .in_mode   (in_mode),
        .in_thresh (in_thresh),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grad  (out_grad),
        .out_pix   (out_pix),
        .out_edge  (out_edge),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mkwin(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic int pu(input int i);  return (i * 37) % 200;     endfunction
    function automatic int pv(input int i);  return (i * 91 + 5) % 256; endfunction
    function automatic int pw(input int i);  return (i * 13) % 128;     endfunction
    function automatic int pth(input int i); return (i * 29) % 256;     endfunction

    // Window i has p3=u, p5=v, p7=w: gx = 2v-2u, gy = 2w.
    task automatic model(input int i, output logic [10:0] g, output logic [7:0] p, output logic e);
        int gx, gy, ax, a;
        gx = 2 * (pv(i) - pu(i));
        gy = 2 * pw(i);
        ax = (gx < 0) ? -gx : gx;
        case (i % 4)
            0: begin g = 11'(gy); a = gy; end
            1: begin g = 11'(gx); a = ax; end
            default: begin a = ax + gy; g = 11'(a); end
        endcase
        p = (a > 255) ? 8'd255 : 8'(a);
        e = (int'(p) >= pth(i));
    endtask

    task automatic push(input logic [71:0] w, input logic [1:0] m, input logic [7:0] th, input logic l);
        int n;
        @(negedge clk);
        in_win = w; in_mode = m; in_thresh = th; in_last = l; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic run1(input logic [71:0] w, input logic [1:0] m, input logic [7:0] th, input logic l);
        out_ready = 1'b1;
        push(w, m, th, l);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        cap_grad = out_grad; cap_pix = out_pix; cap_edge = out_edge; cap_last = out_last;
    endtask

    initial begin
        logic [71:0] w;
        logic [10:0] neg1020;
        neg1020 = 11'(-1020);
        rst = 1'b1; in_valid = 1'b0; in_win = '0; in_mode = 2'd0; in_thresh = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_grad",  32'(out_grad),  32'd0);
        check("rst_out_pix",   32'(out_pix),   32'd0);
        check("rst_out_edge",  32'(out_edge),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Flat window
        run1(mkwin(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'd0, 8'd1, 1'b1);
        check("flat_lat",  32'(lat),      32'd2);
        check("flat_grad", 32'(cap_grad), 32'd0);
        check("flat_pix",  32'(cap_pix),  32'd0);
        check("flat_edge", 32'(cap_edge), 32'd0);
        check("flat_last", 32'(cap_last), 32'd1);
        run1(mkwin(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'd0, 8'd0, 1'b0);
        check("thresh0_edge", 32'(cap_edge), 32'd1);
        check("thresh0_last", 32'(cap_last), 32'd0);

        // Horizontal edge
        run1(mkwin(0, 0, 0, 50, 50, 50, 255, 255, 255), 2'd0, 8'd128, 1'b0);
        check("gy_pos_grad", 32'(cap_grad), 32'd1020);
        check("gy_pos_pix",  32'(cap_pix),  32'd255);
        check("gy_pos_edge", 32'(cap_edge), 32'd1);
        run1(mkwin(255, 255, 255, 50, 50, 50, 0, 0, 0), 2'd0, 8'd128, 1'b0);
        check("gy_neg_grad", 32'(cap_grad), 32'(neg1020));
        check("gy_neg_pix",  32'(cap_pix),  32'd255);

        // Vertical edge
        w = mkwin(0, 9, 255, 0, 9, 255, 0, 9, 255);
        run1(w, 2'd2, 8'd255, 1'b0);
        check("mag_v_grad", 32'(cap_grad), 32'd1020);
        check("mag_v_pix",  32'(cap_pix),  32'd255);
        check("mag_v_edge", 32'(cap_edge), 32'd1);
        run1(w, 2'd1, 8'd255, 1'b0);
        check("gx_v_grad", 32'(cap_grad), 32'd1020);

        // Single pixel p5=10
        w = mkwin(0, 0, 0, 0, 0, 10, 0, 0, 0);
        run1(w, 2'd1, 8'd20, 1'b0);
        check("p5_gx_grad", 32'(cap_grad), 32'd20);
        check("p5_gx_edge", 32'(cap_edge), 32'd1);
        run1(w, 2'd0, 8'd20, 1'b0);
        check("p5_gy_grad", 32'(cap_grad), 32'd0);
        run1(w, 2'd2, 8'd21, 1'b0);
        check("p5_mag_grad", 32'(cap_grad), 32'd20);
        check("p5_mag_pix",  32'(cap_pix),  32'd20);
        check("p5_mag_edge", 32'(cap_edge), 32'd0);
        run1(w, 2'd3, 8'd5, 1'b0);
        check("p5_rsvd_grad", 32'(cap_grad), 32'd20);

        // Stream 16 windows against random backpressure
        fork
            begin : producer
                for (int i = 0; i < 16; i++)
                    push(mkwin(0, 0, 0, 8'(pu(i)), 0, 8'(pv(i)), 0, 8'(pw(i)), 0),
                         2'(i % 4), 8'(pth(i)), (i == 15));
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : consumer
                int got, cyc;
                logic stall;
                logic [10:0] hg, eg;
                logic [7:0] hp, ep;
                logic he, hl, ee;
                got = 0; cyc = 0; stall = 1'b0;
                while (got < 16 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (stall) begin
                        check("hold_valid", 32'(out_valid), 32'd1);
                        check("hold_grad",  32'(out_grad),  32'(hg));
                        check("hold_pix",   32'(out_pix),   32'(hp));
                        check("hold_edge",  32'(out_edge),  32'(he));
                        check("hold_last",  32'(out_last),  32'(hl));
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    stall = 1'b0;
                    if (out_valid && out_ready) begin
                        model(got, eg, ep, ee);
                        check("strm_grad", 32'(out_grad), 32'(eg));
                        check("strm_pix",  32'(out_pix),  32'(ep));
                        check("strm_edge", 32'(out_edge), 32'(ee));
                        check("strm_last", 32'(out_last), 32'(got == 15));
                        $display("stream window %0d: grad=%0d pix=%0d edge=%0d last=%0d",
                                 got, out_grad, out_pix, out_edge, out_last);
                        got++;
                    end else if (out_valid) begin
                        stall = 1'b1;
                        hg = out_grad; hp = out_pix; he = out_edge; hl = out_last;
                    end
                end
                check("strm_count", 32'(got), 32'd16);
            end
        join
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("strm_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset with two windows in flight
        out_ready = 1'b0;
        push(mkwin(0, 0, 0, 0, 0, 50, 0, 0, 0), 2'd1, 8'd0, 1'b0);
        push(mkwin(0, 0, 0, 0, 0, 60, 0, 0, 0), 2'd1, 8'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("flight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run1(w, 2'd1, 8'd5, 1'b0);
        check("post_rst_lat",  32'(lat),      32'd2);
        check("post_rst_grad", 32'(cap_grad), 32'd20);
        check("post_rst_last", 32'(cap_last), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
